// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: default divider parameters and channel-index width helper
package clkdiv_pkg;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_WIDTH = 32;
  localparam int unsigned DEF_DIV = 50000000;
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel with shadowed divisor that reloads only at wrap or while idle
module clkdiv_chan import clkdiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic             sync,
  input  logic [WIDTH-1:0] wr_div,
  output logic             tick,
  output logic             sq,
  output logic             pend
);
  logic [WIDTH-1:0] cnt, act, shd, nxt_shd;
  assign nxt_shd = wr ? wr_div : shd;
  // whenever pend is low shd equals act, so every reload point can take nxt_shd unconditionally
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      tick <= 1'b0;
      sq <= 1'b0;
      pend <= 1'b0;
      act <= WIDTH'(DEFAULT_DIV);
      shd <= WIDTH'(DEFAULT_DIV);
    end else if (sync || !en) begin
      cnt <= '0;
      tick <= 1'b0;
      sq <= 1'b0;
      pend <= 1'b0;
      act <= nxt_shd;
      shd <= nxt_shd;
    end else if (cnt == act) begin
      cnt <= '0;
      tick <= 1'b1;
      sq <= ~sq;
      pend <= 1'b0;
      act <= nxt_shd;
      shd <= nxt_shd;
    end else begin
      cnt <= cnt + WIDTH'(1);
      tick <= 1'b0;
      pend <= pend | wr;
      shd <= nxt_shd;
    end
endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: CHANNELS programmable clock dividers; define CLKDIV_SYNC_EN to add the sync phase-align input
module clkdiv_multi import clkdiv_pkg::*; #(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH = DEF_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          en,
  input  logic                         wr_en,
  input  logic [chan_w(CHANNELS)-1:0]  wr_ch,
  input  logic [WIDTH-1:0]             wr_div,
`ifdef CLKDIV_SYNC_EN
  input  logic                         sync,
`endif
  output logic [CHANNELS-1:0]          tick,
  output logic [CHANNELS-1:0]          sq,
  output logic [CHANNELS-1:0]          pend
);
  localparam int CW = chan_w(CHANNELS);
`ifndef CLKDIV_SYNC_EN
  logic sync;
  assign sync = 1'b0;
`endif
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clkdiv_chan #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .en(en[i]),
      .wr(wr_en && wr_ch == CW'(i)),
      .sync(sync),
      .wr_div(wr_div),
      .tick(tick[i]),
      .sq(sq[i]),
      .pend(pend[i])
    );
  end
endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: randomized scoreboard bench against a countdown period model
module tb_clkdiv_multi;
  localparam int CH = 3;
  localparam int W = 8;
  localparam int DEF = 3;
  logic clk, rst_n, wr_en, sync;
  logic [CH-1:0] en, tick, sq, pend;
  logic [1:0] wr_ch;
  logic [W-1:0] wr_div;
  int checks = 0, failures = 0, cycle = 0;
  logic [3*CH-1:0] exq[$];
  int m_act[CH], m_shd[CH], m_rem[CH];
  bit m_sq[CH], m_tick[CH], m_pend[CH];

  clkdiv_multi #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_div(wr_div),
`ifdef CLKDIV_SYNC_EN
    .sync(sync),
`endif
    .tick(tick),
    .sq(sq),
    .pend(pend)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // advance the reference one edge using the inputs now applied and queue the expected outputs
  task automatic model_push();
    logic [CH-1:0] et, es, ep;
    for (int c = 0; c < CH; c++) begin
      bit w = wr_en && (int'(wr_ch) == c);
      if (!rst_n) begin
        m_act[c] = DEF; m_shd[c] = DEF; m_pend[c] = 0;
        m_rem[c] = DEF + 1; m_sq[c] = 0; m_tick[c] = 0;
      end else if (sync || !en[c]) begin
        if (w) m_shd[c] = int'(wr_div);
        m_act[c] = m_shd[c]; m_pend[c] = 0;
        m_rem[c] = m_act[c] + 1; m_sq[c] = 0; m_tick[c] = 0;
      end else begin
        if (w) begin m_shd[c] = int'(wr_div); m_pend[c] = 1; end
        m_rem[c]--;
        m_tick[c] = (m_rem[c] == 0);
        if (m_tick[c]) begin
          m_sq[c] = !m_sq[c];
          m_act[c] = m_shd[c];
          m_pend[c] = 0;
          m_rem[c] = m_act[c] + 1;
        end
      end
      et[c] = m_tick[c]; es[c] = m_sq[c]; ep[c] = m_pend[c];
    end
    exq.push_back({et, es, ep});
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      model_push();
      @(negedge clk);
      wr_en = 0;
      sync = 0;
    end
  endtask

  task automatic wr(input int ch, input int d);
    wr_en = 1;
    wr_ch = 2'(ch);
    wr_div = W'(d);
  endtask

  task automatic wait_rem(input int c, input int r);
    for (int k = 0; k < 64 && m_rem[c] != r; k++) step(1);
  endtask

  // monitor: every edge produces an output triple; compare it with the oldest prediction
  initial begin
    logic [3*CH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exq.size() != 0) begin
        e = exq.pop_front();
        checks++;
        if ({tick, sq, pend} !== e) begin
          failures++;
          $display("FAIL outputs cycle=%0d tick/sq/pend got=%b/%b/%b want=%b/%b/%b",
                   cycle, tick, sq, pend, e[3*CH-1:2*CH], e[2*CH-1:CH], e[CH-1:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 0; en = '1; wr_en = 0; wr_ch = 0; wr_div = 0; sync = 0;
    @(negedge clk);
    step(2);
    rst_n = 1;
    step(14);
    wait_rem(1, 2); wr(1, 1); step(12);
    wait_rem(2, 1); wr(2, 5); step(16);
    wait_rem(0, 2); en[0] = 0; step(2); wr(0, 2); step(2); en[0] = 1; step(8);
    wr(3, 7); step(6);
`ifdef CLKDIV_SYNC_EN
    wr(0, 1); step(3); wr(1, 3); step(7); sync = 1; step(12);
`endif
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 7) == 0) wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 39) == 0) en[$urandom_range(0, CH - 1)] ^= 1'b1;
`ifdef CLKDIV_SYNC_EN
      if ($urandom_range(0, 59) == 0) sync = 1;
`endif
      step(1);
    end
    for (int k = 0; k < 10 && exq.size() != 0; k++) @(negedge clk);
    if (exq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
